// File: rtl/din_debouncer.sv
// Two-to-four flop synchronizer plus a four-state stability qualifier for a bouncy input pin.
// Define DIN_DEBOUNCER_SVA_EN to compile the built-in concurrent assertions.
module din_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic dout_db,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Bit 0 of the encoding marks the qualifying states, so busy is a plain flop output.
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        CHK_HI  = 2'b01,
        IDLE_HI = 2'b10,
        CHK_LO  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_q;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   dout_db_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE_LO;
            cnt_reg     <= '0;
            dout_db_reg <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                IDLE_LO: begin
                    if (sync_q) begin
                        state_reg <= CHK_HI;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                // A reversal is tested before terminal count, so it always wins.
                CHK_HI: begin
                    if (!sync_q) begin
                        state_reg <= IDLE_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE_HI;
                        dout_db_reg <= 1'b1;
                        rise_reg    <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!sync_q) begin
                        state_reg <= CHK_LO;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                CHK_LO: begin
                    if (sync_q) begin
                        state_reg <= IDLE_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE_LO;
                        dout_db_reg <= 1'b0;
                        fall_reg    <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE_LO;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign dout_db = dout_db_reg;
    assign rise    = rise_reg;
    assign fall    = fall_reg;
    assign busy    = state_reg[0];

`ifdef DIN_DEBOUNCER_SVA_EN
    a_rise_fall_excl: assert property (@(posedge clk) disable iff (rst)
        !(rise_reg && fall_reg))
        $info("a_rise_fall_excl ok at %0t", $time);
        else $error("a_rise_fall_excl violated at %0t", $time);

    a_rise_edge: assert property (@(posedge clk) disable iff (rst)
        rise_reg |-> (dout_db_reg && !$past(dout_db_reg)))
        $info("a_rise_edge ok at %0t", $time);
        else $error("a_rise_edge violated at %0t", $time);

    a_fall_edge: assert property (@(posedge clk) disable iff (rst)
        fall_reg |-> (!dout_db_reg && $past(dout_db_reg)))
        $info("a_fall_edge ok at %0t", $time);
        else $error("a_fall_edge violated at %0t", $time);

    // The first cycle out of reset compares against a value that reset itself cleared.
    a_dout_on_pulse: assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && (dout_db_reg != $past(dout_db_reg))) |-> (rise_reg || fall_reg))
        $info("a_dout_on_pulse ok at %0t", $time);
        else $error("a_dout_on_pulse violated at %0t", $time);

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_reg <= CNT_LAST)
        $info("a_cnt_bound ok at %0t", $time);
        else $error("a_cnt_bound violated at %0t", $time);

    a_post_reset: assert property (@(posedge clk) disable iff (rst)
        $past(rst) |-> (!dout_db_reg && !busy))
        $info("a_post_reset ok at %0t", $time);
        else $error("a_post_reset violated at %0t", $time);
`endif

endmodule

// File: tb/tb_din_debouncer.sv
// Directed bench: a default instance (2 sync stages, 8 stable cycles) and a fast one (3 stages, 2 cycles).
module tb_din_debouncer;

    logic clk;
    logic rst;
    logic raw_in;
    logic dout_db, rise, fall, busy;
    logic dout_db2, rise2, fall2, busy2;

    int passed = 0;
    int total  = 0;

    din_debouncer dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .dout_db (dout_db),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    din_debouncer #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (2)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .dout_db (dout_db2),
        .rise    (rise2),
        .fall    (fall2),
        .busy    (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst    = 1'b1;
        raw_in = 1'b0;
        step();
        step();
        check("rst_dout", dout_db, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", dut.cnt_reg, 0);
        check("rst_dout2", dout_db2, 0);

        // Steady high: commit on edge 10 (default) and edge 5 (fast instance)
        rst    = 1'b0;
        raw_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("hi_dout_e%0d", k), dout_db, k >= 10);
            check($sformatf("hi_rise_e%0d", k), rise, k == 10);
            check($sformatf("hi_fall_e%0d", k), fall, 0);
            check($sformatf("hi_busy_e%0d", k), busy, (k >= 3) && (k <= 9));
            check($sformatf("hi_dout2_e%0d", k), dout_db2, k >= 5);
            check($sformatf("hi_rise2_e%0d", k), rise2, k == 5);
            check($sformatf("hi_busy2_e%0d", k), busy2, k == 4);
        end
        check("hi_cnt_idle", dut.cnt_reg, 0);

        // Steady low from a committed high
        raw_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("lo_dout_e%0d", k), dout_db, k < 10);
            check($sformatf("lo_fall_e%0d", k), fall, k == 10);
            check($sformatf("lo_rise_e%0d", k), rise, 0);
            check($sformatf("lo_busy_e%0d", k), busy, (k >= 3) && (k <= 9));
            check($sformatf("lo_dout2_e%0d", k), dout_db2, k < 5);
            check($sformatf("lo_fall2_e%0d", k), fall2, k == 5);
        end

        // Three-cycle glitch is rejected by the default instance
        for (int k = 1; k <= 15; k++) begin
            raw_in = (k <= 3);
            step();
            check($sformatf("gl_dout_e%0d", k), dout_db, 0);
            check($sformatf("gl_rise_e%0d", k), rise, 0);
            if (k == 4) check("gl_busy_mid", busy, 1);
        end
        check("gl_busy_end", busy, 0);
        check("gl_cnt_end", dut.cnt_reg, 0);
        check("gl_dout2_end", dout_db2, 0);

        // Bounce every cycle, then steady high
        for (int k = 1; k <= 30; k++) begin
            raw_in = k[0];
            step();
            check($sformatf("bn_dout_e%0d", k), dout_db, 0);
            check($sformatf("bn_rise_e%0d", k), rise, 0);
            check($sformatf("bn_dout2_e%0d", k), dout_db2, 0);
        end
        raw_in = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("bs_dout_e%0d", j), dout_db, j >= 10);
            check($sformatf("bs_rise_e%0d", j), rise, j == 10);
            check($sformatf("bs_dout2_e%0d", j), dout_db2, j >= 5);
            check($sformatf("bs_rise2_e%0d", j), rise2, j == 5);
        end

        // Reset in the middle of qualification
        rst    = 1'b1;
        raw_in = 1'b0;
        step();
        check("mr_pre_dout", dout_db, 0);
        check("mr_pre_dout2", dout_db2, 0);
        rst    = 1'b0;
        raw_in = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("mr_q_dout_e%0d", j), dout_db, 0);
        end
        check("mr_q_busy", busy, 1);
        rst = 1'b1;
        step();
        check("mr_rst_dout", dout_db, 0);
        check("mr_rst_busy", busy, 0);
        check("mr_rst_cnt", dut.cnt_reg, 0);
        check("mr_rst_dout2", dout_db2, 0);
        check("mr_rst_rise2", rise2, 0);
        rst = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            step();
            check($sformatf("mr_dout_e%0d", m), dout_db, m >= 10);
            check($sformatf("mr_rise_e%0d", m), rise, m == 10);
            check($sformatf("mr_busy_e%0d", m), busy, (m >= 3) && (m <= 9));
            check($sformatf("mr_dout2_e%0d", m), dout_db2, m >= 5);
            check($sformatf("mr_rise2_e%0d", m), rise2, m == 5);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
